axi4_read_responder: RTL and testbench

- Synthesizable AXI4 read-slave endpoint backed by an internal 64-bit word memory. It is the far end of the DMA's AXI4 read-master port.
- Accepts one AR request at a time and returns R bursts (FIXED/INCR/WRAP) with full RVALID/RREADY back-pressure.
- Used as the source memory in DMA system benches and as a small on-chip ROM/SRAM slave. A backdoor write port preloads contents.

---
 rtl/axi4_read_responder_pkg.sv | 19 +
 rtl/axi_burst_addr_gen.sv | 38 +++
 rtl/axi4_read_responder.sv | 143 ++++++++++++++
 tb/tb_axi4_read_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_read_responder_pkg.sv
// Shared AXI4 encodings and the burst-legality helper for the read responder
// and the burst address generator.
package axi4_read_responder_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  // A WRAP container must hold 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-word-address and legality check for one AXI4 burst beat.
// Addresses are in 64-bit word units; WA_WIDTH must be at least 8.
module axi_burst_addr_gen
  import axi4_read_responder_pkg::*;
#(
  parameter int WA_WIDTH = 29
) (
  input  logic [WA_WIDTH-1:0] addr,
  input  logic [7:0]          len,
  input  logic [1:0]          burst,
  input  logic [2:0]          size,
  output logic [WA_WIDTH-1:0] next_addr,
  output logic                legal
);

  logic [WA_WIDTH-1:0] wrap_mask;
  logic [WA_WIDTH-1:0] incr_addr;

  assign wrap_mask = WA_WIDTH'(len);
  assign incr_addr = addr + WA_WIDTH'(1);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    next_addr = addr;
    legal     = 1'b1;
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_INCR:  next_addr = incr_addr;
      AXI_BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        legal     = wrap_len_ok(len);
      end
      default:         legal = 1'b0;
    endcase
    if (size != AXI_SIZE_8B) legal = 1'b0;
  end

endmodule

// File: rtl/axi4_read_responder.sv
// AXI4 read-slave endpoint over an internal 64-bit word memory with a
// backdoor preload port; one AR at a time, R beats with full back-pressure.
module axi4_read_responder
  import axi4_read_responder_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ID_WIDTH-1:0]      ARID,
  input  logic [ADDR_WIDTH-1:0]    ARADDR,
  input  logic [7:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [ID_WIDTH-1:0]      RID,
  output logic [63:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     MemWrEn,
  input  logic [$clog2(DEPTH)-1:0] MemWrAddr,
  input  logic [63:0]              MemWrData
);

  localparam int WA_WIDTH = ADDR_WIDTH - 3;
  localparam int MEM_AW   = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [WA_WIDTH-1:0] addr;
    logic [7:0]          len;
    logic [1:0]          burst;
    logic [2:0]          size;
  } ar_req_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state;
  ar_req_t             req;
  ar_req_t             cur;
  logic [7:0]          beat_cnt;
  logic [7:0]          cur_beat;
  logic [WA_WIDTH-1:0] next_addr;
  logic                burst_legal;
  logic                in_range;
  logic                ar_hs;
  logic                last_hs;
  logic                load_beat;
  logic [63:0]         mem [DEPTH];

  // Byte offset within a 64-bit word carries no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ARADDR[2:0];

  // Beat 0 is served straight from the AR channel so RVALID follows the
  // handshake by one cycle; later beats come from the latched request.
  always_comb begin
    cur      = req;
    cur_beat = beat_cnt;
    if (state == S_IDLE) begin
      cur      = '{id: ARID, addr: ARADDR[ADDR_WIDTH-1:3], len: ARLEN,
                   burst: ARBURST, size: ARSIZE};
      cur_beat = '0;
    end
  end

  assign ar_hs     = (state == S_IDLE) && ARVALID && ARREADY;
  assign last_hs   = RVALID && RREADY && RLAST;
  assign load_beat = ar_hs ||
                     ((state == S_BURST) && !(RVALID && RLAST) && (!RVALID || RREADY));
  assign in_range  = (cur.addr[WA_WIDTH-1:MEM_AW] == '0);

  axi_burst_addr_gen #(.WA_WIDTH(WA_WIDTH)) u_addr_gen (
    .addr      (cur.addr),
    .len       (cur.len),
    .burst     (cur.burst),
    .size      (cur.size),
    .next_addr (next_addr),
    .legal     (burst_legal)
  );

  // NOTE: the memory array has no reset; only control and output registers do.
  always_ff @(posedge ACLK) begin
    if (MemWrEn) mem[MemWrAddr] <= MemWrData;
  end

  // NOTE: sequential state uses non-blocking assignments, so a backdoor write
  // landing on the word being loaded returns the old contents this cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= S_IDLE;
      req      <= '0;
      beat_cnt <= '0;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RRESP    <= AXI_RESP_OKAY;
      RID      <= '0;
      RDATA    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ARREADY <= 1'b1;
          if (ar_hs) begin
            ARREADY <= 1'b0;
            req     <= cur;
            state   <= S_BURST;
          end
        end
        S_BURST: begin
          if (last_hs) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (load_beat) begin
        RVALID   <= 1'b1;
        RID      <= cur.id;
        RLAST    <= (cur_beat == cur.len);
        req.addr <= next_addr;
        beat_cnt <= cur_beat + 8'd1;
        if (burst_legal && in_range) begin
          RDATA <= mem[cur.addr[MEM_AW-1:0]];
          RRESP <= AXI_RESP_OKAY;
        end else begin
          RDATA <= '0;
          RRESP <= AXI_RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_read_responder.sv
// Directed bench for axi4_read_responder: bursts, errors, back-pressure,
// reset mid-burst and backdoor write collision, with hand-computed expectations.
module tb_axi4_read_responder;
  import axi4_read_responder_pkg::*;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH      = 16;

  logic                  ACLK;
  logic                  ARESET;
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [63:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;
  logic                  MemWrEn;
  logic [3:0]            MemWrAddr;
  logic [63:0]           MemWrData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] ed [16];
  logic [1:0]  er [16];

  axi4_read_responder #(
    .ID_WIDTH   (ID_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .MemWrEn   (MemWrEn),
    .MemWrAddr (MemWrAddr),
    .MemWrData (MemWrData)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_beat(input int i, input logic [63:0] d, input logic [1:0] r);
    ed[4'(i)] = d;
    er[4'(i)] = r;
  endtask

  task automatic mem_write(input logic [3:0] a, input logic [63:0] d);
    @(negedge ACLK);
    MemWrEn   = 1'b1;
    MemWrAddr = a;
    MemWrData = d;
    @(posedge ACLK);
    #1;
    MemWrEn = 1'b0;
  endtask

  // Presents one AR and returns 1 time unit after the handshake edge.
  task automatic ar_send(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    int waited = 0;
    @(negedge ACLK);
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARBURST = burst;
    ARSIZE  = size;
    ARVALID = 1'b1;
    while (!ARREADY && waited < 20) begin
      @(negedge ACLK);
      waited++;
    end
    check({tag, "_ar_accept"}, 64'(ARREADY), 64'd1);
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    check({tag, "_first_rvalid"}, 64'(RVALID), 64'd1);
    check({tag, "_arready_low"}, 64'(ARREADY), 64'd0);
  endtask

  // Drains n beats using a 4-cycle RREADY pattern, checking each accepted
  // beat against ed/er and output stability on every stalled cycle.
  task automatic read_burst(input string tag, input int n, input logic [3:0] pat,
                            input logic [3:0] exp_id);
    int          beat = 0;
    int          cyc  = 0;
    logic        stall = 1'b0;
    logic [63:0] sd;
    logic [1:0]  sr;
    logic        sl;
    while (beat < n && cyc < 200) begin
      @(negedge ACLK);
      if (stall) begin
        check($sformatf("%s_stall_valid%0d", tag, beat), 64'(RVALID), 64'd1);
        check($sformatf("%s_stall_data%0d", tag, beat), RDATA, sd);
        check($sformatf("%s_stall_resp%0d", tag, beat), 64'(RRESP), 64'(sr));
        check($sformatf("%s_stall_last%0d", tag, beat), 64'(RLAST), 64'(sl));
      end
      RREADY = pat[2'(cyc)];
      check($sformatf("%s_arready_busy%0d", tag, cyc), 64'(ARREADY), 64'd0);
      stall = RVALID && !RREADY;
      sd = RDATA;
      sr = RRESP;
      sl = RLAST;
      if (RVALID && RREADY) begin
        check($sformatf("%s_data%0d", tag, beat), RDATA, ed[4'(beat)]);
        check($sformatf("%s_resp%0d", tag, beat), 64'(RRESP), 64'(er[4'(beat)]));
        check($sformatf("%s_id%0d", tag, beat), 64'(RID), 64'(exp_id));
        check($sformatf("%s_last%0d", tag, beat), 64'(RLAST), 64'(beat == n - 1));
        beat++;
      end
      cyc++;
    end
    check({tag, "_beats_done"}, 64'(beat), 64'(n));
    if (pat == 4'b1111) check({tag, "_no_bubble"}, 64'(cyc), 64'(n));
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    check({tag, "_rvalid_drop"}, 64'(RVALID), 64'd0);
    check({tag, "_arready_back"}, 64'(ARREADY), 64'd1);
  endtask

  initial begin
    ARESET    = 1'b1;
    ARID      = '0;
    ARADDR    = '0;
    ARLEN     = '0;
    ARSIZE    = AXI_SIZE_8B;
    ARBURST   = AXI_BURST_INCR;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    MemWrEn   = 1'b0;
    MemWrAddr = '0;
    MemWrData = '0;

    // Reset state and ARREADY rising one cycle after release
    #12;
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_rlast", 64'(RLAST), 64'd0);
    check("rst_rresp", 64'(RRESP), 64'd0);
    check("rst_rid", 64'(RID), 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    check("rel_arready_low", 64'(ARREADY), 64'd0);
    @(posedge ACLK);
    #1;
    check("rel_arready_high", 64'(ARREADY), 64'd1);

    for (int i = 0; i < 16; i++) mem_write(4'(i), 64'(i) * 64'h0101);

    // INCR from word 2, four beats
    exp_beat(0, 64'h0202, AXI_RESP_OKAY);
    exp_beat(1, 64'h0303, AXI_RESP_OKAY);
    exp_beat(2, 64'h0404, AXI_RESP_OKAY);
    exp_beat(3, 64'h0505, AXI_RESP_OKAY);
    ar_send("incr", 4'h5, 32'h10, 8'd3, AXI_BURST_INCR, AXI_SIZE_8B);
    read_burst("incr", 4, 4'b1111, 4'h5);

    // WRAP over the 4-word container 4..7 starting at word 5
    exp_beat(0, 64'h0505, AXI_RESP_OKAY);
    exp_beat(1, 64'h0606, AXI_RESP_OKAY);
    exp_beat(2, 64'h0707, AXI_RESP_OKAY);
    exp_beat(3, 64'h0404, AXI_RESP_OKAY);
    ar_send("wrap", 4'hA, 32'h28, 8'd3, AXI_BURST_WRAP, AXI_SIZE_8B);
    read_burst("wrap", 4, 4'b1111, 4'hA);

    // WRAP with a 3-beat container is illegal
    for (int i = 0; i < 3; i++) exp_beat(i, 64'h0, AXI_RESP_SLVERR);
    ar_send("wrap3", 4'h1, 32'h28, 8'd2, AXI_BURST_WRAP, AXI_SIZE_8B);
    read_burst("wrap3", 3, 4'b1111, 4'h1);

    // FIXED at word 3 with nonzero byte offset
    for (int i = 0; i < 3; i++) exp_beat(i, 64'h0303, AXI_RESP_OKAY);
    ar_send("fixed", 4'h2, 32'h1F, 8'd2, AXI_BURST_FIXED, AXI_SIZE_8B);
    read_burst("fixed", 3, 4'b1111, 4'h2);

    // Back-pressure with RREADY 1,0,0,1 over an 8-beat INCR
    exp_beat(0, 64'h0000, AXI_RESP_OKAY);
    exp_beat(1, 64'h0101, AXI_RESP_OKAY);
    exp_beat(2, 64'h0202, AXI_RESP_OKAY);
    exp_beat(3, 64'h0303, AXI_RESP_OKAY);
    exp_beat(4, 64'h0404, AXI_RESP_OKAY);
    exp_beat(5, 64'h0505, AXI_RESP_OKAY);
    exp_beat(6, 64'h0606, AXI_RESP_OKAY);
    exp_beat(7, 64'h0707, AXI_RESP_OKAY);
    ar_send("bp", 4'h9, 32'h0, 8'd7, AXI_BURST_INCR, AXI_SIZE_8B);
    read_burst("bp", 8, 4'b1001, 4'h9);

    // INCR running past the last word: OKAY, OKAY, SLVERR, SLVERR
    exp_beat(0, 64'h0e0e, AXI_RESP_OKAY);
    exp_beat(1, 64'h0f0f, AXI_RESP_OKAY);
    exp_beat(2, 64'h0000, AXI_RESP_SLVERR);
    exp_beat(3, 64'h0000, AXI_RESP_SLVERR);
    ar_send("range", 4'h7, 32'h70, 8'd3, AXI_BURST_INCR, AXI_SIZE_8B);
    read_burst("range", 4, 4'b1111, 4'h7);

    // Reserved burst type and illegal size
    for (int i = 0; i < 2; i++) exp_beat(i, 64'h0, AXI_RESP_SLVERR);
    ar_send("rsvd", 4'h3, 32'h0, 8'd1, 2'b11, AXI_SIZE_8B);
    read_burst("rsvd", 2, 4'b1111, 4'h3);
    ar_send("size4", 4'h4, 32'h8, 8'd1, AXI_BURST_INCR, 3'b010);
    read_burst("size4", 2, 4'b1111, 4'h4);

    // Reset asserted while beat 2 of an 8-beat burst is presented
    RREADY = 1'b1;
    ar_send("mid", 4'hC, 32'h0, 8'd7, AXI_BURST_INCR, AXI_SIZE_8B);
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    check("mid_beat2_data", RDATA, 64'h0202);
    #1;
    ARESET = 1'b1;
    #1;
    check("mid_rvalid_async", 64'(RVALID), 64'd0);
    check("mid_rlast_async", 64'(RLAST), 64'd0);
    check("mid_arready_async", 64'(ARREADY), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    RREADY = 1'b0;
    check("mid_rel_arready_low", 64'(ARREADY), 64'd0);
    @(posedge ACLK);
    #1;
    check("mid_rel_arready_high", 64'(ARREADY), 64'd1);
    check("mid_rel_rvalid", 64'(RVALID), 64'd0);
    exp_beat(0, 64'h0404, AXI_RESP_OKAY);
    ar_send("single", 4'hD, 32'h20, 8'd0, AXI_BURST_INCR, AXI_SIZE_8B);
    read_burst("single", 1, 4'b1111, 4'hD);

    // Backdoor write to word 3 in the cycle beat 3 loads returns old data
    RREADY = 1'b1;
    ar_send("coll", 4'h6, 32'h0, 8'd5, AXI_BURST_INCR, AXI_SIZE_8B);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("coll_data%0d", k), RDATA, 64'(k) * 64'h0101);
      check($sformatf("coll_last%0d", k), 64'(RLAST), 64'(k == 5));
      if (k == 2) begin
        MemWrEn   = 1'b1;
        MemWrAddr = 4'd3;
        MemWrData = 64'hDEAD_BEEF_0000_0003;
      end
      if (k == 3) MemWrEn = 1'b0;
      @(posedge ACLK);
      #1;
    end
    RREADY = 1'b0;
    check("coll_rvalid_drop", 64'(RVALID), 64'd0);
    exp_beat(0, 64'hDEAD_BEEF_0000_0003, AXI_RESP_OKAY);
    ar_send("coll_new", 4'h8, 32'h18, 8'd0, AXI_BURST_FIXED, AXI_SIZE_8B);
    read_burst("coll_new", 1, 4'b1111, 4'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
